// File: rtl/img_xform_pkg.sv
// img_xform_pkg: shared encodings and defaults for the frame transform sequencer
//   MODE_*  : op_mode encodings for mode_req and the adapter op_mode
//   state_t : sequencer states
//   ERR_*   : err_code values reported to the system controller
package img_xform_pkg;
    localparam int IMG_W_DEF = 1024;
    localparam int IMG_H_DEF = 1024;
    localparam int N_PIX_DEF = IMG_W_DEF * IMG_H_DEF;
    localparam logic [2:0] MODE_STORE   = 3'b000;
    localparam logic [2:0] MODE_ROT_CCW = 3'b001;
    localparam logic [2:0] MODE_LINEAR  = 3'b110;
    localparam logic [2:0] MODE_ILLEGAL = 3'b111;
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_UNDERRUN = 2'b01;
    localparam logic [1:0] ERR_MODE     = 2'b10;
    localparam logic [1:0] ERR_DONE     = 2'b11;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_READ, S_DRAIN, S_FIN} state_t;
endpackage

// File: rtl/pix_xy_counter.sv
// pix_xy_counter: raster pixel counter split into column and row
//   en_i advances, clr_i zeroes (clear wins); idx_o/col_o/row_o give the position;
//   last_col_o flags column IMG_W-1, last_pix_o flags index IMG_W*IMG_H-1.
//   All counts wrap to zero after their last value.
module pix_xy_counter
    import img_xform_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        clr_i,
    output logic [19:0] idx_o,
    output logic [9:0]  col_o,
    output logic [9:0]  row_o,
    output logic        last_pix_o,
    output logic        last_col_o
);
    localparam logic [19:0] LAST_IDX = 20'(IMG_W * IMG_H - 1);
    localparam logic [9:0]  LAST_COL = 10'(IMG_W - 1);
    localparam logic [9:0]  LAST_ROW = 10'(IMG_H - 1);

    logic [19:0] idx_q, idx_d;
    logic [9:0]  col_q, col_d, row_q, row_d;

    assign last_pix_o = idx_q == LAST_IDX;
    assign last_col_o = col_q == LAST_COL;
    assign idx_o      = idx_q;
    assign col_o      = col_q;
    assign row_o      = row_q;

    always_comb begin
        idx_d = clr_i ? '0 : en_i ? (last_pix_o ? '0 : idx_q + 20'd1) : idx_q;
        col_d = clr_i ? '0 : en_i ? (last_col_o ? '0 : col_q + 10'd1) : col_q;
        row_d = clr_i ? '0 : (en_i && last_col_o) ? (row_q == LAST_ROW ? '0 : row_q + 10'd1) : row_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            idx_q <= idx_d;
            col_q <= col_d;
            row_q <= row_d;
        end
    end
endmodule

// File: rtl/frame_xform_ctrl.sv
// frame_xform_ctrl: sequences one store pass and one transform pass of the adapter
//   start/mode_req      : pass request, sampled only in IDLE
//   busy/done/err/err_code : status to the system controller
//   pix_in_*            : continuous upstream stream written during LOAD
//   pix_out_*           : reframed SRAM read data with SOF/EOL markers
//   adp_*               : adapter reset, op_mode, data_in and its data_out/output_done
module frame_xform_ctrl
    import img_xform_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  mode_req,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    input  logic        pix_in_valid,
    input  logic [23:0] pix_in,
    output logic        pix_in_ready,
    output logic        pix_out_valid,
    output logic [23:0] pix_out,
    output logic        pix_out_sof,
    output logic        pix_out_eol,
    output logic        adp_rst,
    output logic [2:0]  adp_op_mode,
    output logic [23:0] adp_data_in,
    input  logic [23:0] adp_data_out,
    input  logic        adp_output_done
);
    localparam int DW = $clog2(RD_LAT + 1);

    state_t      state_q, state_d;
    logic [2:0]  mode_q, mode_d, op_mode_q;
    logic [1:0]  err_code_q, code_d;
    logic        err_q, err_d, mis_q, mis_d, chk_bad, post_rd_q, adp_rst_q;
    logic [DW-1:0]     drain_q, drain_d;
    logic [RD_LAT-1:0] vld_q, sof_q, eol_q;
    logic [19:0] in_idx, out_idx;
    logic [9:0]  in_col, in_row, out_col, out_row;
    logic        in_last, in_last_col, out_last, out_last_col, rd_now;
    logic        unused_ok;

    pix_xy_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_in_cnt (
        .clk(clk), .rst(rst), .en_i(state_q == S_LOAD), .clr_i(state_q == S_IDLE),
        .idx_o(in_idx), .col_o(in_col), .row_o(in_row),
        .last_pix_o(in_last), .last_col_o(in_last_col)
    );

    pix_xy_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_out_cnt (
        .clk(clk), .rst(rst), .en_i(state_q == S_READ), .clr_i(state_q == S_IDLE),
        .idx_o(out_idx), .col_o(out_col), .row_o(out_row),
        .last_pix_o(out_last), .last_col_o(out_last_col)
    );

    assign unused_ok = ^{in_idx, in_col, in_row, in_last_col, out_col, out_row};
    assign rd_now    = state_q == S_READ;

    // Adapter done must be low through GAP/READ and high exactly on the cycle after the last read.
    assign chk_bad = ((state_q == S_GAP || rd_now) && adp_output_done) || (post_rd_q && !adp_output_done);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        err_d   = 1'b0;
        code_d  = err_code_q;
        mis_d   = mis_q | chk_bad;
        drain_d = '0;
        unique case (state_q)
            S_IDLE: if (start) begin
                mode_d = mode_req;
                code_d = ERR_NONE;
                mis_d  = 1'b0;
                if (mode_req == MODE_ILLEGAL) begin
                    err_d  = 1'b1;
                    code_d = ERR_MODE;
                end else begin
                    state_d = mode_req == MODE_LINEAR ? S_GAP : S_LOAD;
                end
            end
            S_LOAD: if (!pix_in_valid) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
                code_d  = ERR_UNDERRUN;
            end else if (in_last) begin
                state_d = mode_q == MODE_STORE ? S_FIN : S_GAP;
            end
            S_GAP:  state_d = S_READ;
            S_READ: state_d = out_last ? S_DRAIN : S_READ;
            S_DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DW'(RD_LAT - 1)) begin
                    state_d = S_FIN;
                    drain_d = '0;
                    err_d   = mis_d;
                    code_d  = mis_d ? ERR_DONE : err_code_q;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_STORE;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            mis_q      <= 1'b0;
            post_rd_q  <= 1'b0;
            drain_q    <= '0;
            adp_rst_q  <= 1'b1;
            op_mode_q  <= MODE_STORE;
            vld_q      <= '0;
            sof_q      <= '0;
            eol_q      <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            err_q      <= err_d;
            err_code_q <= code_d;
            mis_q      <= mis_d;
            post_rd_q  <= rd_now && out_last;
            drain_q    <= drain_d;
            // Adapter is held in reset whenever it is not loading or reading, which also zeroes its x/y in GAP.
            adp_rst_q  <= state_d == S_IDLE || state_d == S_GAP || state_d == S_FIN;
            op_mode_q  <= (state_d == S_GAP || state_d == S_READ || state_d == S_DRAIN) ? mode_d : MODE_STORE;
            vld_q      <= (vld_q << 1) | RD_LAT'(rd_now);
            sof_q      <= (sof_q << 1) | RD_LAT'(rd_now && out_idx == '0);
            eol_q      <= (eol_q << 1) | RD_LAT'(rd_now && out_last_col);
        end
    end

    assign busy          = state_q != S_IDLE;
    assign done          = state_q == S_FIN;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign pix_in_ready  = state_q == S_LOAD;
    assign pix_out_valid = vld_q[RD_LAT-1];
    assign pix_out_sof   = sof_q[RD_LAT-1];
    assign pix_out_eol   = eol_q[RD_LAT-1];
    assign pix_out       = pix_out_valid ? adp_data_out : '0;
    assign adp_rst       = rst | adp_rst_q;
    assign adp_op_mode   = op_mode_q;
    assign adp_data_in   = pix_in;
endmodule
